seg7_scan_driver: RTL and testbench

//  Time-multiplexed N-digit hex driver for common-anode 7-segment banks.

---
 rtl/seg7_scan_driver.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit hex driver for common-anode 7-segment banks
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 8,
  parameter int BLANK_CYCLES = 2,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic                    load_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    lz_blank_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS) + 1;
  localparam int DW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // Idle (dark) levels in pin polarity
  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic [DW-1:0]   shadow, shadow_n;
  logic [DW-1:0]   captured, captured_n;
  logic            pending, pending_n;
  logic            boundary;
  logic            frame_n;
  logic [NUM_DIGITS-1:0] lzb;
  logic [NUM_DIGITS-1:0] an_on;
  logic [3:0]      nib;
  logic [6:0]      code;
  logic            zero_above;

  // Active-low segment code for one hex nibble
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Scan sequencing, frame-synchronous word capture, and next-cycle output values
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 1'b1;
    idx_n      = idx;
    boundary   = 1'b0;
    shadow_n   = shadow;
    captured_n = captured;
    pending_n  = pending;
    lzb        = '0;
    an_on      = '0;
    nib        = 4'h0;
    code       = 7'h7F;
    zero_above = 1'b1;
    frame_n    = 1'b0;

    case (state)
      ST_BLANK: begin
        if (cnt == BL_LAST) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
        end
      end
      default: begin
        if (cnt == ON_LAST) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          if (idx == IDX_LAST) begin
            idx_n    = '0;
            boundary = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
    endcase

    // The shadow only changes at the frame boundary, so a frame never mixes words
    if (boundary) begin
      pending_n = 1'b0;
      if (load_i)       shadow_n = data_i;
      else if (pending) shadow_n = captured;
    end else if (load_i) begin
      captured_n = data_i;
      pending_n  = 1'b1;
    end

    // Leading-zero mask scanned from the most significant digit down; digit 0 never masked
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (shadow_n[4*k +: 4] == 4'h0);
      lzb[k]     = lz_blank_i && zero_above;
    end

    if (state_n == ST_SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_n == IW'(k)) begin
          an_on[k] = digit_en_i[k] && !lzb[k];
          nib      = shadow_n[4*k +: 4];
        end
      end
    end

    if (|an_on) code = decode(nib);

    frame_n = (state_n == ST_SHOW) && (idx_n == IDX_LAST) && (cnt_n == ON_LAST);
  end

  // State and registered pin outputs; outputs are loaded with the values for the cycle being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_BLANK;
      cnt      <= '0;
      idx      <= '0;
      shadow   <= '0;
      captured <= '0;
      pending  <= 1'b0;
      seg_o    <= SEG_OFF;
      an_o     <= AN_OFF;
      frame_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shadow   <= shadow_n;
      captured <= captured_n;
      pending  <= pending_n;
      seg_o    <= ACTIVE_LOW ? code : ~code;
      an_o     <= ACTIVE_LOW ? ~an_on : an_on;
      frame_o  <= frame_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  en = 4'hF;
  logic        lz = 1'b0;
  logic [6:0]  seg, seg1;
  logic [3:0]  an, an1;
  logic        frame, frame1;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int multi  = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .ON_CYCLES(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .data_i(data), .load_i(load), .digit_en_i(en),
    .lz_blank_i(lz), .seg_o(seg), .an_o(an), .frame_o(frame)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .ON_CYCLES(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .data_i(data), .load_i(load), .digit_en_i(en),
    .lz_blank_i(lz), .seg_o(seg1), .an_o(an1), .frame_o(frame1)
  );

  always #5 clk = ~clk;

  // Watch for more than one active anode in either polarity
  always @(negedge clk) begin
    if ($countones(~an) > 1 || $countones(an1) > 1) multi <= multi + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load_word(input logic [15:0] w);
    data = w;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Scenario 1: reset and first digit
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_frame", 16'(frame), 16'h0);
    chk("rst_an_hi", 16'(an1), 16'h0);
    release_rst();
    goto(1);
    chk("c1_an_blank", 16'(an), 16'hF);
    goto(2);
    chk("c2_an", 16'(an), 16'hE);
    chk("c2_seg", 16'(seg), 16'h40);
    chk("c2_an_hi", 16'(an1), 16'h1);
    chk("c2_seg_hi", 16'(seg1), 16'h3F);
    goto(9);
    chk("c9_an", 16'(an), 16'hE);
    goto(10);
    chk("c10_an_blank", 16'(an), 16'hF);
    chk("c10_seg_blank", 16'(seg), 16'h7F);
    goto(12);
    chk("c12_an", 16'(an), 16'hD);

    // Scenario 2: mid-frame load held until boundary
    goto(20);
    load_word(16'h12AF);
    goto(32);
    chk("old_d3_an", 16'(an), 16'h7);
    chk("old_d3_seg", 16'(seg), 16'h40);
    goto(38);
    chk("frame_38", 16'(frame), 16'h0);
    goto(39);
    chk("frame_39", 16'(frame), 16'h1);
    goto(40);
    chk("frame_40", 16'(frame), 16'h0);
    goto(42);
    chk("w_d0_seg", 16'(seg), 16'h0E);
    chk("w_d0_an", 16'(an), 16'hE);
    goto(52);
    chk("w_d1_seg", 16'(seg), 16'h08);
    chk("w_d1_an", 16'(an), 16'hD);
    goto(62);
    chk("w_d2_seg", 16'(seg), 16'h24);
    chk("w_d2_an", 16'(an), 16'hB);
    goto(72);
    chk("w_d3_seg", 16'(seg), 16'h79);
    chk("w_d3_an", 16'(an), 16'h7);
    goto(79);
    chk("frame_79", 16'(frame), 16'h1);

    // Scenario 3: leading-zero blanking
    goto(80);
    lz = 1'b1;
    load_word(16'h0030);
    goto(122);
    chk("lz_d0_seg", 16'(seg), 16'h40);
    chk("lz_d0_an", 16'(an), 16'hE);
    goto(132);
    chk("lz_d1_seg", 16'(seg), 16'h30);
    chk("lz_d1_an", 16'(an), 16'hD);
    goto(142);
    chk("lz_d2_an", 16'(an), 16'hF);
    chk("lz_d2_seg", 16'(seg), 16'h7F);
    goto(152);
    chk("lz_d3_an", 16'(an), 16'hF);
    goto(160);
    load_word(16'h0000);
    goto(202);
    chk("lz0_d0_an", 16'(an), 16'hE);
    chk("lz0_d0_seg", 16'(seg), 16'h40);
    goto(212);
    chk("lz0_d1_an", 16'(an), 16'hF);

    // Scenario 4: digit enables and overwriting load
    goto(240);
    lz = 1'b0;
    en = 4'b0101;
    load_word(16'h1111);
    goto(245);
    load_word(16'h2222);
    goto(282);
    chk("en_d0_seg", 16'(seg), 16'h24);
    chk("en_d0_an", 16'(an), 16'hE);
    goto(292);
    chk("en_d1_an", 16'(an), 16'hF);
    chk("en_d1_seg", 16'(seg), 16'h7F);
    goto(302);
    chk("en_d2_an", 16'(an), 16'hB);
    goto(312);
    chk("en_d3_an", 16'(an), 16'hF);
    goto(319);
    chk("en_frame_319", 16'(frame), 16'h1);

    // Scenario 5: load on the boundary cycle
    goto(320);
    en = 4'hF;
    goto(352);
    chk("pre_d3_seg", 16'(seg), 16'h24);
    goto(359);
    chk("bnd_frame", 16'(frame), 16'h1);
    load_word(16'h0E5B);
    goto(362);
    chk("bnd_d0_seg", 16'(seg), 16'h03);
    goto(372);
    chk("bnd_d1_seg", 16'(seg), 16'h12);
    goto(382);
    chk("bnd_d2_seg", 16'(seg), 16'h06);
    goto(392);
    chk("bnd_d3_seg", 16'(seg), 16'h40);
    chk("bnd_d3_an", 16'(an), 16'h7);
    goto(402);
    chk("bnd_next_d0", 16'(seg), 16'h03);

    // Asynchronous reset mid-SHOW
    goto(405);
    rst = 1'b1;
    #1;
    chk("arst_an", 16'(an), 16'hF);
    chk("arst_seg", 16'(seg), 16'h7F);
    chk("arst_an_hi", 16'(an1), 16'h0);
    release_rst();
    goto(2);
    chk("rs_c2_an", 16'(an), 16'hE);
    chk("rs_c2_seg", 16'(seg), 16'h40);
    goto(12);
    chk("rs_c12_an", 16'(an), 16'hD);

    chk("onehot", 16'(multi), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
